logic_unit: RTL and testbench
=============================

LOGIC_UNIT -- requirements
Module: logic_unit

Interface
- REQ-001: Parameter WIDTH, default 16, operand and result width in bits.
- REQ-002: clk, input, 1, single clock; all state updates on rising edge.
- REQ-003: rst, input, 1, reset, asynchronous and active-high.
- REQ-004: in_valid, input, 1, Opcode/A/B are valid and are captured this cycle.
- REQ-005: Opcode, input, 4, operation select; bit 3 set means logic-class operation.
- REQ-006: A, input, WIDTH, operand A.
- REQ-007: B, input, WIDTH, operand B.
- REQ-008: Result, output, WIDTH, registered operation result.
- REQ-009: Sel, output, 1, registered flag; high when the captured Opcode was logic-class (Opcode[3]=1).
- REQ-010: out_valid, output, 1, registered; high for exactly one cycle per accepted input.
- REQ-011: Zero, output, 1, registered; high when Result is all zeros (present only with LOGIC_UNIT_ZERO_FLAG_EN).

Function
- REQ-012: Opcode decode SHALL be as follows.
  - 1000: A AND B
  - 1001: A OR B
  - 1010: A XOR B
  - 1011: NOT(A AND B)
  - 1100: NOT(A OR B)
  - 1101: NOT(A XOR B)
  - 1110: NOT A
  - 1111: NOT B
- REQ-013: Opcodes 0000-0111 SHALL produce Result=0 and Sel=0, with out_valid still asserted.
- REQ-014: All operations SHALL be bitwise over WIDTH bits, with no carry and no sign extension.
- REQ-015: Latency SHALL be exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on Result/Sel/out_valid after edge N.
- REQ-016: When in_valid=0, Result, Sel and Zero SHALL hold their previous values and out_valid SHALL be 0.
- REQ-017: Back-to-back in_valid=1 SHALL give one result per cycle with no stall.
- REQ-018: No backpressure; the consumer SHALL take each result in the cycle out_valid=1.
- REQ-019: Unknown or X-free behaviour: every Opcode value SHALL map to a defined Result.

Reset
- REQ-020: While rst=1, Result=0, Sel=0, out_valid=0, and Zero=1 (when present), asynchronously and independent of clk.
- REQ-021: An in_valid transfer coinciding with rst SHALL be discarded.
- REQ-022: After rst deasserts, the first accepted input SHALL produce out_valid one cycle later.

Configuration
- REQ-023: Macro LOGIC_UNIT_ZERO_FLAG_EN SHALL control the Zero output.
  - Defined: Zero port exists and updates with Result.
  - Undefined: Zero port and its register are absent.
  - Result, Sel and out_valid SHALL be identical in both builds.

Verification
- REQ-024: A=FFFC, B=9FFF, in_valid=1; Opcode 1000/1001/1010/1011 -> Result 9FFC/FFFF/6003/6003, Sel=1, one cycle later.
- REQ-025: Same A and B; Opcode 1100/1101/1110/1111 -> Result 0000/9FFC/0003/6000, Sel=1; Zero=1 only for 1100 (with macro).
- REQ-026: Opcode 0101, A=1234, B=5678 -> Result=0000, Sel=0, out_valid=1.
- REQ-027: Eight back-to-back valid ops -> eight consecutive out_valid pulses in order; then in_valid=0 -> out_valid=0 and Result held at 6000.
- REQ-028: Assert rst mid-stream between clock edges -> outputs are immediately 0 (Zero=1) and the pending transfer produces no out_valid.

Source files
------------

// File: rtl/logic_unit.sv
// Registered bitwise logic unit: one-cycle latency, one result per accepted input.
// Optional Zero flag output is built in only when LOGIC_UNIT_ZERO_FLAG_EN is defined.
module logic_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [3:0]       Opcode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Result,
   output logic             Sel,
   output logic             out_valid
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
   ,
   output logic             Zero
`endif
);

   logic [WIDTH-1:0] w_result;
   logic             w_sel;

   logic [WIDTH-1:0] r_result;
   logic             r_sel;
   logic             r_out_valid;

   // Non-logic opcodes (bit 3 clear) deliberately decode to an all-zero result.
   always_comb begin
      w_result = '0;
      w_sel    = Opcode[3];
      if (Opcode[3]) begin
         unique case (Opcode[2:0])
            3'b000:  w_result = A & B;
            3'b001:  w_result = A | B;
            3'b010:  w_result = A ^ B;
            3'b011:  w_result = ~(A & B);
            3'b100:  w_result = ~(A | B);
            3'b101:  w_result = ~(A ^ B);
            3'b110:  w_result = ~A;
            3'b111:  w_result = ~B;
            default: w_result = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result    <= '0;
         r_sel       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_result <= w_result;
            r_sel    <= w_sel;
         end
      end
   end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
   logic r_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero <= 1'b1;
      end else if (in_valid) begin
         r_zero <= (w_result == '0);
      end
   end

   assign Zero = r_zero;
`endif

   assign Result    = r_result;
   assign Sel       = r_sel;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_logic_unit.sv
// Scoreboard bench for logic_unit: expected results are queued at capture and
// compared one cycle later; checks Zero too when LOGIC_UNIT_ZERO_FLAG_EN is defined.
module tb_logic_unit;

   localparam int unsigned W = 16;

   typedef struct packed {
      logic [W-1:0] res;
      logic         sel;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [3:0]   Opcode;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] Result;
   logic         Sel;
   logic         out_valid;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
   logic         Zero;
`endif

   exp_t         sb_q[$];
   logic [W-1:0] hold_res;
   logic         hold_sel;
   int           n_vec;
   int           n_err;

   logic_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .Opcode    (Opcode),
      .A         (A),
      .B         (B),
      .Result    (Result),
      .Sel       (Sel),
      .out_valid (out_valid)
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      ,
      .Zero      (Zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      exp_t e;
      e.sel = op[3];
      case (op)
         4'b1000: e.res = a & b;
         4'b1001: e.res = a | b;
         4'b1010: e.res = a ^ b;
         4'b1011: e.res = ~(a & b);
         4'b1100: e.res = ~(a | b);
         4'b1101: e.res = ~(a ^ b);
         4'b1110: e.res = ~a;
         4'b1111: e.res = ~b;
         default: e.res = '0;
      endcase
      return e;
   endfunction

   task automatic check_hold(input string tag);
      check_eq({tag, ".vld"}, 32'(out_valid), 32'd0);
      check_eq({tag, ".res"}, 32'(Result), 32'(hold_res));
      check_eq({tag, ".sel"}, 32'(Sel), 32'(hold_sel));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      check_eq({tag, ".zero"}, 32'(Zero), 32'(hold_res == '0));
`endif
   endtask

   // Drive one cycle's inputs, capture at the edge, compare 1 ns later.
   task automatic cycle(input string tag, input logic v, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      in_valid = v;
      Opcode   = op;
      A        = a;
      B        = b;
      @(posedge clk);
      if (v && !rst) sb_q.push_back(model(op, a, b));
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         hold_res = e.res;
         hold_sel = e.sel;
         check_eq({tag, ".vld"}, 32'(out_valid), 32'd1);
         check_eq({tag, ".res"}, 32'(Result), 32'(e.res));
         check_eq({tag, ".sel"}, 32'(Sel), 32'(e.sel));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
         check_eq({tag, ".zero"}, 32'(Zero), 32'(e.res == '0));
`endif
      end else begin
         check_hold(tag);
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      hold_res = '0;
      hold_sel = 1'b0;
      rst      = 1'b1;
      in_valid = 1'b1;
      Opcode   = 4'b1001;
      A        = 16'hFFFF;
      B        = 16'hFFFF;

      // Reset state, with a transfer offered that must be ignored.
      repeat (2) @(posedge clk);
      #1;
      check_hold("reset");
      rst = 1'b0;

      cycle("idle", 1'b0, 4'b0000, 16'h0000, 16'h0000);

      // Eight logic ops back to back; last result (NOT B) must then hold.
      for (int i = 0; i < 8; i++) begin
         cycle($sformatf("op%0d", 8 + i), 1'b1, 4'(8 + i), 16'hFFFC, 16'h9FFF);
      end
      cycle("hold0", 1'b0, 4'b1000, 16'h0000, 16'h0000);
      cycle("hold1", 1'b0, 4'b0101, 16'h1234, 16'h1234);
      check_eq("hold_6000", 32'(Result), 32'h6000);

      cycle("arith0101", 1'b1, 4'b0101, 16'h1234, 16'h5678);
      for (int i = 0; i < 8; i++) begin
         cycle($sformatf("nonlogic%0d", i), 1'b1, 4'(i), 16'hA5A5, 16'h0FF0);
      end

      for (int i = 0; i < 24; i++) begin
         cycle($sformatf("rnd%0d", i), 1'(($urandom_range(0, 3)) != 0),
               4'($urandom_range(0, 15)), 16'($urandom()), 16'($urandom()));
      end

      // Mid-cycle reset: outputs clear at once and the pending transfer is dropped.
      cycle("pre_rst", 1'b1, 4'b1001, 16'h1200, 16'h0034);
      in_valid = 1'b1;
      Opcode   = 4'b1111;
      A        = 16'h0000;
      B        = 16'h0000;
      #4;
      rst = 1'b1;
      #1;
      hold_res = '0;
      hold_sel = 1'b0;
      check_hold("rst_async");
      @(posedge clk);
      #1;
      check_hold("rst_drop");
      #2;
      rst = 1'b0;

      cycle("post_rst_idle", 1'b0, 4'b1000, 16'hFFFF, 16'hFFFF);
      cycle("post_rst_first", 1'b1, 4'b1010, 16'hF0F0, 16'h0FF0);
      cycle("post_rst_end", 1'b0, 4'b0000, 16'h0000, 16'h0000);

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
